spam1_cpu: RTL and testbench
============================

// Module: spam1_cpu
// PURPOSE
//  Single-cycle 8-bit SPAM-1 CPU core: fetches one 48-bit microword per clock from an internal 64K ROM, runs an
//  ALU op on A/B bus sources, conditionally writes one target register/device, and advances or loads a 16-bit PC.
//  Top of the CPU hierarchy; a UART byte channel is the only external I/O.
// PARAMETERS
//  ROM_FILE  ""  hex image for $readmemh into rom[] at time 0; empty = none, rom[] is preloaded hierarchically.
// PORTS
//  RESET_SWITCH  in   1   reset, asynchronous, active-high; positional port 1
//  clk           in   1   single clock, rising edge; positional port 2
//  uart_rx_data  in   8   received byte
//  uart_rx_valid in   1   rx byte available (condition DI)
//  uart_rx_ack   out  1   1-cycle pulse: executed instr read source uart
//  uart_tx_data  out  8   byte to send; held until next uart write
//  uart_tx_valid out  1   1-cycle pulse: executed instr wrote target uart
//  uart_tx_ready in   1   tx can accept byte (condition DO)
// BEHAVIOUR
//  Word: [47:43] aluop, [42:38] target, [37:35] asel, [34:32] bsel, [31:28] cond, [27] set_flags, [26] cond_inv
//   (CM_INV=1), [25] amode (1=direct addr, 0=MAR), [24] rsvd, [23:8] address, [7:0] immed.
//  asel: 0 rega,1 regb,2 regc,3 regd,4 marlo,5 marhi,6 uart(rx_data),7 not_used(=0).
//  bsel: 0 rega,1 regb,2 regc,3 regd,4 marlo,5 marhi,6 immed,7 ram[addr].
//  aluop (0-15): ZERO,A,B,NOT_A,A+B,A-B,B-A,A+B+C,A-B-C,A&B,A|B,A^B,A+1,A-1,B+1,B-1; 16-31 yield 0.
//   8-bit wrap; C = carry/not-borrow, Z = result==0, N = bit7, O = signed overflow (logic ops clear C,O).
//  cond: 0 A(always),1 C,2 Z,3 O,4 N,5 EQ(Z),6 NE(!Z),7 GT(C&!Z),8 LT(!C),9 DI,10 DO, 11-15 never.
//   exec = cond_true ^ cond_inv.
//  target: 0 rega,1 regb,2 regc,3 regd,4 marlo,5 marhi,6 uart,7 ram,8 pchitmp,9 pclo,10 pc, 11-31 no write.
//  Per rising edge, if exec: write target; flags <= ALU flags iff set_flags. If !exec: no write, no flag change,
//   no uart pulses. RAM address = amode ? address : {marhi,marlo}.
//  PC: exec & target pc -> PC <= {pchitmp,result}; exec & pclo -> {PC[15:8],result}; else PC+1 (wraps FFFF->0).
//  Jump = pchitmp write then pc write; a conditional jump is two instrs, second gated by cond.
//  Combinational fetch: instr = rom[PC]; uart pulses/tx_data combinational from current instr & exec.
//  Reset (async): PC, all regs, MAR, pchitmp, flags = 0; instr = rom[0]; pulses 0; tx_data 0; RAM not cleared.
//  Release: first edge executes rom[0]. Reset mid-program aborts current instruction (no write).
// CONFIGURATION
//  SPAM1_DISASM_EN: defined -> sim-only functions string disasm(logic[47:0]) and disasmCur() (disasm of rom[PC]),
//   plus a $display trace per executed instr. Undefined -> none present; datapath identical.
// STRUCTURE
//  Package spam1_pkg: enums aluop_t, target_t, asel_t, bsel_t, cond_t; field-position localparams; CM_STD/CM_INV.
//  Sub-module spam1_alu (aluop, a, b, cin -> result, c, z, n, o), combinational. Rest (decode, regs, ROM 64Kx48,
//   RAM 64Kx8, PC) inline in spam1_cpu.
// TESTING
//  Reset: RESET_SWITCH=1 mid-run -> PC=0, rega..regd=0, flags=0 immediately, no uart pulses.
//  ALU/flags: rega=FF, immed 01, A+B set_flags -> result 00, C=1, Z=1; same with set_flags=0 -> flags unchanged.
//  Cond jump: pchitmp=12, pc immed 34 cond Z: Z=1 -> PC=1234; Z=0 -> PC+1; cond_inv flips both.
//  Echo loop: rega=0,regb=0; spin on DI(inv) until rx_valid with rx_data 'H'; read -> rega='H', rx_ack 1 cycle;
//   spin on DO(inv) with tx_ready=0 for 5 cycles, then 1 -> tx_data='H', tx_valid 1 cycle; jump back to wait.
//  RAM: direct amode write 5A to addr 0100, read via bsel ram with MAR=0100 -> 5A.
//  PC wrap: PC=FFFF non-jump -> PC=0000.

Source files
------------

// File: rtl/spam1_pkg.sv
// Shared encodings for the SPAM-1 microword: field positions, ALU ops, selectors and conditions.
package spam1_pkg;

  typedef enum logic [4:0] {
    ALU_ZERO = 5'd0,  ALU_A    = 5'd1,  ALU_B    = 5'd2,  ALU_NOTA = 5'd3,
    ALU_ADD  = 5'd4,  ALU_SUB  = 5'd5,  ALU_RSUB = 5'd6,  ALU_ADC  = 5'd7,
    ALU_SBC  = 5'd8,  ALU_AND  = 5'd9,  ALU_OR   = 5'd10, ALU_XOR  = 5'd11,
    ALU_INCA = 5'd12, ALU_DECA = 5'd13, ALU_INCB = 5'd14, ALU_DECB = 5'd15
  } aluop_t;

  typedef enum logic [4:0] {
    TGT_REGA = 5'd0, TGT_REGB = 5'd1, TGT_REGC = 5'd2, TGT_REGD = 5'd3,
    TGT_MARLO = 5'd4, TGT_MARHI = 5'd5, TGT_UART = 5'd6, TGT_RAM = 5'd7,
    TGT_PCHITMP = 5'd8, TGT_PCLO = 5'd9, TGT_PC = 5'd10
  } target_t;

  typedef enum logic [2:0] {
    ASEL_REGA = 3'd0, ASEL_REGB = 3'd1, ASEL_REGC = 3'd2, ASEL_REGD = 3'd3,
    ASEL_MARLO = 3'd4, ASEL_MARHI = 3'd5, ASEL_UART = 3'd6, ASEL_NONE = 3'd7
  } asel_t;

  typedef enum logic [2:0] {
    BSEL_REGA = 3'd0, BSEL_REGB = 3'd1, BSEL_REGC = 3'd2, BSEL_REGD = 3'd3,
    BSEL_MARLO = 3'd4, BSEL_MARHI = 3'd5, BSEL_IMMED = 3'd6, BSEL_RAM = 3'd7
  } bsel_t;

  typedef enum logic [3:0] {
    COND_A = 4'd0, COND_C = 4'd1, COND_Z = 4'd2, COND_O = 4'd3, COND_N = 4'd4,
    COND_EQ = 4'd5, COND_NE = 4'd6, COND_GT = 4'd7, COND_LT = 4'd8,
    COND_DI = 4'd9, COND_DO = 4'd10
  } cond_t;

  localparam int ALUOP_HI  = 47;
  localparam int ALUOP_LO  = 43;
  localparam int TARGET_HI = 42;
  localparam int TARGET_LO = 38;
  localparam int ASEL_HI   = 37;
  localparam int ASEL_LO   = 35;
  localparam int BSEL_HI   = 34;
  localparam int BSEL_LO   = 32;
  localparam int COND_HI   = 31;
  localparam int COND_LO   = 28;
  localparam int SETF_BIT  = 27;
  localparam int CINV_BIT  = 26;
  localparam int AMODE_BIT = 25;
  localparam int RSVD_BIT  = 24;
  localparam int ADDR_HI   = 23;
  localparam int ADDR_LO   = 8;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;

  localparam logic CM_STD = 1'b0;
  localparam logic CM_INV = 1'b1;

endpackage

// File: rtl/spam1_alu.sv
// Combinational 8-bit ALU; all arithmetic runs through one adder as x + y + ci,
// so carry-out is a true carry for adds and a not-borrow for subtracts.
module spam1_alu
  import spam1_pkg::*;
(
  input  logic [4:0] aluop,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] result,
  output logic       c,
  output logic       z,
  output logic       n,
  output logic       o
);

  logic [7:0] x;
  logic [7:0] y;
  logic       ci;
  logic       arith;
  logic [7:0] logic_r;
  logic [8:0] sum;

  // Subtraction is x + ~y + 1; subtract-with-carry uses ~cin so it computes A-B-C.
  always_comb begin
    x       = a;
    y       = 8'h00;
    ci      = 1'b0;
    arith   = 1'b0;
    logic_r = 8'h00;
    case (aluop)
      ALU_ZERO: logic_r = 8'h00;
      ALU_A:    logic_r = a;
      ALU_B:    logic_r = b;
      ALU_NOTA: logic_r = ~a;
      ALU_ADD:  begin arith = 1'b1; y = b; end
      ALU_SUB:  begin arith = 1'b1; y = ~b; ci = 1'b1; end
      ALU_RSUB: begin arith = 1'b1; x = b; y = ~a; ci = 1'b1; end
      ALU_ADC:  begin arith = 1'b1; y = b; ci = cin; end
      ALU_SBC:  begin arith = 1'b1; y = ~b; ci = ~cin; end
      ALU_AND:  logic_r = a & b;
      ALU_OR:   logic_r = a | b;
      ALU_XOR:  logic_r = a ^ b;
      ALU_INCA: begin arith = 1'b1; ci = 1'b1; end
      ALU_DECA: begin arith = 1'b1; y = 8'hFF; end
      ALU_INCB: begin arith = 1'b1; x = b; ci = 1'b1; end
      ALU_DECB: begin arith = 1'b1; x = b; y = 8'hFF; end
      default:  logic_r = 8'h00;
    endcase
  end

  assign sum    = {1'b0, x} + {1'b0, y} + {8'b0, ci};
  assign result = arith ? sum[7:0] : logic_r;
  assign c      = arith & sum[8];
  assign o      = arith & (x[7] == y[7]) & (sum[7] != x[7]);
  assign z      = (result == 8'h00);
  assign n      = result[7];

endmodule

// File: rtl/spam1_cpu.sv
// Single-cycle SPAM-1 core: ROM fetch, decode, ALU, register/RAM/UART writeback and PC update.
// Optional SPAM1_DISASM_EN adds simulation-only disassembly helpers and an execution trace.
module spam1_cpu
  import spam1_pkg::*;
#(
  parameter string ROM_FILE = ""
) (
  input  logic       RESET_SWITCH,
  input  logic       clk,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_valid,
  output logic       uart_rx_ack,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready
);

  logic rst;
  assign rst = RESET_SWITCH;

  logic [47:0] rom [0:65535];
  logic [7:0]  ram [0:65535];

  logic [15:0] pc;
  logic [7:0]  rega, regb, regc, regd, marlo, marhi, pchitmp, tx_hold;
  logic        flag_c, flag_z, flag_n, flag_o;

  logic [47:0] instr;
  logic [4:0]  aluop, target;
  logic [2:0]  asel, bsel;
  logic [3:0]  cond;
  logic        set_flags, cond_inv, amode, unused_rsvd;
  logic [15:0] address, ram_addr;
  logic [7:0]  immed, ram_q, abus, bbus, alu_r;
  logic        alu_c, alu_z, alu_n, alu_o;
  logic        cond_true, exec;

  assign instr       = rom[pc];
  assign aluop       = instr[ALUOP_HI:ALUOP_LO];
  assign target      = instr[TARGET_HI:TARGET_LO];
  assign asel        = instr[ASEL_HI:ASEL_LO];
  assign bsel        = instr[BSEL_HI:BSEL_LO];
  assign cond        = instr[COND_HI:COND_LO];
  assign set_flags   = instr[SETF_BIT];
  assign cond_inv    = instr[CINV_BIT];
  assign amode       = instr[AMODE_BIT];
  assign unused_rsvd = instr[RSVD_BIT];
  assign address     = instr[ADDR_HI:ADDR_LO];
  assign immed       = instr[IMM_HI:IMM_LO];

  assign ram_addr = amode ? address : {marhi, marlo};
  assign ram_q    = ram[ram_addr];

  always_comb begin
    abus = 8'h00;
    case (asel)
      ASEL_REGA:  abus = rega;
      ASEL_REGB:  abus = regb;
      ASEL_REGC:  abus = regc;
      ASEL_REGD:  abus = regd;
      ASEL_MARLO: abus = marlo;
      ASEL_MARHI: abus = marhi;
      ASEL_UART:  abus = uart_rx_data;
      default:    abus = 8'h00;
    endcase
  end

  always_comb begin
    bbus = 8'h00;
    case (bsel)
      BSEL_REGA:  bbus = rega;
      BSEL_REGB:  bbus = regb;
      BSEL_REGC:  bbus = regc;
      BSEL_REGD:  bbus = regd;
      BSEL_MARLO: bbus = marlo;
      BSEL_MARHI: bbus = marhi;
      BSEL_IMMED: bbus = immed;
      default:    bbus = ram_q;
    endcase
  end

  spam1_alu u_alu (
    .aluop  (aluop),
    .a      (abus),
    .b      (bbus),
    .cin    (flag_c),
    .result (alu_r),
    .c      (alu_c),
    .z      (alu_z),
    .n      (alu_n),
    .o      (alu_o)
  );

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_A:  cond_true = 1'b1;
      COND_C:  cond_true = flag_c;
      COND_Z:  cond_true = flag_z;
      COND_O:  cond_true = flag_o;
      COND_N:  cond_true = flag_n;
      COND_EQ: cond_true = flag_z;
      COND_NE: cond_true = ~flag_z;
      COND_GT: cond_true = flag_c & ~flag_z;
      COND_LT: cond_true = ~flag_c;
      COND_DI: cond_true = uart_rx_valid;
      COND_DO: cond_true = uart_tx_ready;
      default: cond_true = 1'b0;
    endcase
  end

  // Reset masks execution so no write or UART pulse can escape while it is held.
  assign exec          = (cond_true ^ cond_inv) & ~rst;
  assign uart_rx_ack   = exec & (asel == ASEL_UART);
  assign uart_tx_valid = exec & (target == TGT_UART);
  assign uart_tx_data  = uart_tx_valid ? alu_r : tx_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= 16'h0000;
      rega    <= 8'h00;
      regb    <= 8'h00;
      regc    <= 8'h00;
      regd    <= 8'h00;
      marlo   <= 8'h00;
      marhi   <= 8'h00;
      pchitmp <= 8'h00;
      tx_hold <= 8'h00;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_o  <= 1'b0;
    end else begin
      if (exec) begin
        case (target)
          TGT_REGA:    rega    <= alu_r;
          TGT_REGB:    regb    <= alu_r;
          TGT_REGC:    regc    <= alu_r;
          TGT_REGD:    regd    <= alu_r;
          TGT_MARLO:   marlo   <= alu_r;
          TGT_MARHI:   marhi   <= alu_r;
          TGT_UART:    tx_hold <= alu_r;
          TGT_PCHITMP: pchitmp <= alu_r;
          default:     ;
        endcase
      end
      if (exec && set_flags) begin
        flag_c <= alu_c;
        flag_z <= alu_z;
        flag_n <= alu_n;
        flag_o <= alu_o;
      end
      if (exec && target == TGT_PC)
        pc <= {pchitmp, alu_r};
      else if (exec && target == TGT_PCLO)
        pc <= {pc[15:8], alu_r};
      else
        pc <= pc + 16'd1;
    end
  end

  // RAM contents survive reset, so it sits outside the reset domain.
  always_ff @(posedge clk) begin
    if (exec && target == TGT_RAM)
      ram[ram_addr] <= alu_r;
  end

`ifdef SPAM1_DISASM_EN
  function automatic string disasm(input logic [47:0] w);
    return $sformatf("op=%0d tgt=%0d a=%0d b=%0d cond=%0d%s sf=%0b am=%0b addr=%04h imm=%02h",
                     w[ALUOP_HI:ALUOP_LO], w[TARGET_HI:TARGET_LO], w[ASEL_HI:ASEL_LO],
                     w[BSEL_HI:BSEL_LO], w[COND_HI:COND_LO], w[CINV_BIT] ? "!" : "",
                     w[SETF_BIT], w[AMODE_BIT], w[ADDR_HI:ADDR_LO], w[IMM_HI:IMM_LO]);
  endfunction

  function automatic string disasmCur();
    return disasm(rom[pc]);
  endfunction

  always @(posedge clk) begin
    if (exec)
      $display("spam1 pc=%04h %s result=%02h", pc, disasmCur(), alu_r);
  end
`endif

endmodule

// File: tb/tb_spam1_cpu.sv
// Directed bench for spam1_cpu: preloads ROM hierarchically, drives a linear program
// through flags, jumps, RAM, UART echo, reset and PC wrap, checking via a scoreboard queue.
module tb_spam1_cpu;

  localparam logic [4:0] OP_ZERO = 5'd0, OP_A = 5'd1, OP_B = 5'd2, OP_ADD = 5'd4;
  localparam logic [4:0] T_REGA = 5'd0, T_REGB = 5'd1, T_REGC = 5'd2, T_REGD = 5'd3;
  localparam logic [4:0] T_MARLO = 5'd4, T_MARHI = 5'd5, T_UART = 5'd6, T_RAM = 5'd7;
  localparam logic [4:0] T_PCHI = 5'd8, T_PCLO = 5'd9, T_PC = 5'd10, T_NONE = 5'd31;
  localparam logic [2:0] A_REGA = 3'd0, A_UART = 3'd6;
  localparam logic [2:0] B_REGA = 3'd0, B_IMM = 3'd6, B_RAM = 3'd7;
  localparam logic [3:0] C_A = 4'd0, C_Z = 4'd2, C_DI = 4'd9, C_DO = 4'd10;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  spam1_cpu dut (
    .RESET_SWITCH  (rst),
    .clk           (clk),
    .uart_rx_data  (rx_data),
    .uart_rx_valid (rx_valid),
    .uart_rx_ack   (rx_ack),
    .uart_tx_data  (tx_data),
    .uart_tx_valid (tx_valid),
    .uart_tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] mk(input logic [4:0] op, input logic [4:0] tgt,
                                     input logic [2:0] as, input logic [2:0] bs,
                                     input logic [3:0] cnd, input logic sf, input logic inv,
                                     input logic am, input logic [15:0] adr, input logic [7:0] imm);
    return {op, tgt, as, bs, cnd, sf, inv, am, 1'b0, adr, imm};
  endfunction

  task automatic pushExp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_empty: got %0h, required a pending expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("[TB] FAIL %s: got %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    dut.rom[16'h0000] = mk(OP_B,    T_REGA, A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'hFF);
    dut.rom[16'h0001] = mk(OP_ADD,  T_REGA, A_REGA, B_IMM, C_A, 1'b1, 1'b0, 1'b0, 16'h0, 8'h01);
    dut.rom[16'h0002] = mk(OP_ADD,  T_REGB, A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'hFF);
    dut.rom[16'h0003] = mk(OP_B,    T_PCHI, A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h12);
    dut.rom[16'h0004] = mk(OP_B,    T_PC,   A_REGA, B_IMM, C_Z, 1'b0, 1'b0, 1'b0, 16'h0, 8'h34);
    dut.rom[16'h1234] = mk(OP_B,    T_REGC, A_REGA, B_IMM, C_A, 1'b1, 1'b0, 1'b0, 16'h0, 8'h05);
    dut.rom[16'h1235] = mk(OP_B,    T_PC,   A_REGA, B_IMM, C_Z, 1'b0, 1'b0, 1'b0, 16'h0, 8'h50);
    dut.rom[16'h1236] = mk(OP_B,    T_PC,   A_REGA, B_IMM, C_Z, 1'b0, 1'b1, 1'b0, 16'h0, 8'h40);
    dut.rom[16'h1240] = mk(OP_ZERO, T_NONE, A_REGA, B_REGA, C_A, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00);
    dut.rom[16'h1241] = mk(OP_B,    T_PC,   A_REGA, B_IMM, C_Z, 1'b0, 1'b1, 1'b0, 16'h0, 8'h00);
    dut.rom[16'h1242] = mk(OP_B,    T_RAM,  A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b1, 16'h0100, 8'h5A);
    dut.rom[16'h1243] = mk(OP_B,    T_MARLO, A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    dut.rom[16'h1244] = mk(OP_B,    T_MARHI, A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h01);
    dut.rom[16'h1245] = mk(OP_B,    T_REGD, A_REGA, B_RAM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    dut.rom[16'h1246] = mk(OP_ZERO, T_REGA, A_REGA, B_REGA, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    dut.rom[16'h1247] = mk(OP_ZERO, T_REGB, A_REGA, B_REGA, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    dut.rom[16'h1248] = mk(OP_B,    T_PCLO, A_REGA, B_IMM, C_DI, 1'b0, 1'b1, 1'b0, 16'h0, 8'h48);
    dut.rom[16'h1249] = mk(OP_A,    T_REGA, A_UART, B_REGA, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    dut.rom[16'h124A] = mk(OP_B,    T_PCLO, A_REGA, B_IMM, C_DO, 1'b0, 1'b1, 1'b0, 16'h0, 8'h4A);
    dut.rom[16'h124B] = mk(OP_A,    T_UART, A_REGA, B_REGA, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    dut.rom[16'h124C] = mk(OP_B,    T_PCLO, A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h48);

    // Held in reset: everything cleared, no UART activity.
    pushExp("reset_pc", 32'h0);
    pushExp("reset_rega", 32'h0);
    pushExp("reset_rx_ack", 32'h0);
    pushExp("reset_tx_valid", 32'h0);
    pushExp("reset_tx_data", 32'h0);
    applyStimulus(2);
    checkOutput(dut.pc);
    checkOutput(dut.rega);
    checkOutput(rx_ack);
    checkOutput(tx_valid);
    checkOutput(tx_data);

    rst = 1'b0;
    pushExp("first_instr_rega", 32'hFF);
    pushExp("first_instr_pc", 32'h1);
    applyStimulus(1);
    checkOutput(dut.rega);
    checkOutput(dut.pc);

    // FF + 01 wraps to 00 with carry and zero.
    pushExp("add_result", 32'h00);
    pushExp("add_c", 32'h1);
    pushExp("add_z", 32'h1);
    pushExp("add_o", 32'h0);
    applyStimulus(1);
    checkOutput(dut.rega);
    checkOutput(dut.flag_c);
    checkOutput(dut.flag_z);
    checkOutput(dut.flag_o);

    pushExp("nosf_regb", 32'hFF);
    pushExp("nosf_z_kept", 32'h1);
    pushExp("nosf_c_kept", 32'h1);
    applyStimulus(1);
    checkOutput(dut.regb);
    checkOutput(dut.flag_z);
    checkOutput(dut.flag_c);

    pushExp("jump_z_taken", 32'h1234);
    applyStimulus(2);
    checkOutput(dut.pc);

    pushExp("clear_z", 32'h0);
    applyStimulus(1);
    checkOutput(dut.flag_z);

    pushExp("jump_z_not_taken", 32'h1236);
    applyStimulus(1);
    checkOutput(dut.pc);

    pushExp("jump_inv_taken", 32'h1240);
    applyStimulus(1);
    checkOutput(dut.pc);

    pushExp("set_z", 32'h1);
    applyStimulus(1);
    checkOutput(dut.flag_z);

    pushExp("jump_inv_not_taken", 32'h1242);
    applyStimulus(1);
    checkOutput(dut.pc);

    pushExp("ram_direct_write", 32'h5A);
    applyStimulus(1);
    checkOutput(dut.ram[16'h0100]);

    pushExp("ram_mar_read", 32'h5A);
    applyStimulus(3);
    checkOutput(dut.regd);

    pushExp("echo_rega_cleared", 32'h0);
    applyStimulus(2);
    checkOutput(dut.rega);

    // Spin on DI until a byte arrives.
    pushExp("spin_di_pc", 32'h1248);
    pushExp("spin_di_no_ack", 32'h0);
    applyStimulus(3);
    checkOutput(dut.pc);
    checkOutput(rx_ack);

    rx_valid = 1'b1;
    rx_data  = 8'h48;
    pushExp("rx_leave_spin_pc", 32'h1249);
    pushExp("rx_ack_pulse", 32'h1);
    applyStimulus(1);
    checkOutput(dut.pc);
    checkOutput(rx_ack);
    rx_valid = 1'b0;

    pushExp("rx_rega", 32'h48);
    pushExp("rx_ack_drop", 32'h0);
    applyStimulus(1);
    checkOutput(dut.rega);
    checkOutput(rx_ack);

    for (int i = 0; i < 5; i++) begin
      pushExp("spin_do_pc", 32'h124A);
      pushExp("spin_do_no_tx", 32'h0);
      applyStimulus(1);
      checkOutput(dut.pc);
      checkOutput(tx_valid);
    end

    tx_ready = 1'b1;
    pushExp("tx_valid_pulse", 32'h1);
    pushExp("tx_data_h", 32'h48);
    applyStimulus(1);
    checkOutput(tx_valid);
    checkOutput(tx_data);
    tx_ready = 1'b0;

    pushExp("tx_valid_drop", 32'h0);
    pushExp("tx_data_held", 32'h48);
    applyStimulus(1);
    checkOutput(tx_valid);
    checkOutput(tx_data);

    pushExp("echo_loop_back", 32'h1248);
    applyStimulus(1);
    checkOutput(dut.pc);

    // Asynchronous reset mid-run.
    rst = 1'b1;
    #1;
    pushExp("midreset_pc", 32'h0);
    pushExp("midreset_rega", 32'h0);
    pushExp("midreset_regd", 32'h0);
    pushExp("midreset_flag_z", 32'h0);
    pushExp("midreset_rx_ack", 32'h0);
    pushExp("midreset_tx_valid", 32'h0);
    pushExp("midreset_tx_data", 32'h0);
    pushExp("midreset_ram_kept", 32'h5A);
    checkOutput(dut.pc);
    checkOutput(dut.rega);
    checkOutput(dut.regd);
    checkOutput(dut.flag_z);
    checkOutput(rx_ack);
    checkOutput(tx_valid);
    checkOutput(tx_data);
    checkOutput(dut.ram[16'h0100]);

    dut.rom[16'h0000] = mk(OP_B, T_PCHI, A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'hFF);
    dut.rom[16'h0001] = mk(OP_B, T_PC,   A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'hFF);
    dut.rom[16'hFFFF] = mk(OP_B, T_REGC, A_REGA, B_IMM, C_A, 1'b0, 1'b0, 1'b0, 16'h0, 8'h77);
    applyStimulus(1);
    rst = 1'b0;

    pushExp("jump_to_ffff", 32'hFFFF);
    applyStimulus(2);
    checkOutput(dut.pc);

    pushExp("pc_wrap", 32'h0000);
    pushExp("wrap_regc", 32'h77);
    applyStimulus(1);
    checkOutput(dut.pc);
    checkOutput(dut.regc);

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
